// File: rtl/fpu_pkg.sv
// Shared constants and types for the binary32 add/sub sequencer.
// Field offsets, special encodings, flag bit positions and the FSM state encoding.
package fpu_pkg;

  localparam int FP32_W     = 32;
  localparam int SIGN_BIT   = 31;
  localparam int EXP_MSB    = 30;
  localparam int EXP_LSB    = 23;
  localparam int MAN_MSB    = 22;
  localparam int EXP_BIAS   = 127;
  localparam int EXP_MAX    = 255;

  localparam logic [FP32_W-1:0] QNAN_CANON = 32'h7FC0_0000;

  // out_flags = {NV, OF, NX}
  localparam int FLAG_NV = 2;
  localparam int FLAG_OF = 1;
  localparam int FLAG_NX = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_ADD   = 3'd2,
    ST_NORM  = 3'd3,
    ST_ROUND = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/leading_zeroth_bit.sv
// Leading-zero counter: number of zero bits above the most significant one.
// An all-zero input returns Bit_Length.
module leading_zeroth_bit #(
  parameter int Bit_Length   = 25,
  parameter int Bit_Length_O = 6
) (
  input  logic [Bit_Length-1:0]   in_bits,
  output logic [Bit_Length_O-1:0] lz
);

  always_comb begin
    lz = Bit_Length_O'(Bit_Length);
    // Scanning upward, the last set bit seen is the leading one.
    for (int i = 0; i < Bit_Length; i++) begin
      if (in_bits[i]) begin
        lz = Bit_Length_O'(Bit_Length - 1 - i);
      end
    end
  end

endmodule

// File: rtl/fpu_add_seq.sv
// Multi-cycle binary32 add/sub: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE.
// Subnormals flush to zero; round to nearest even; specials resolved at accept.
module fpu_add_seq
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int LZC_W = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic                 in_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_result,
  output logic [2:0]           out_flags
);

  localparam int FP_W = EXP_W + MAN_W + 1;
  localparam int FW   = MAN_W + 4;   // {hidden, mantissa, G, R, S}
  localparam int SW   = MAN_W + 5;   // FW plus carry
  localparam int NW   = MAN_W + 2;   // {carry, hidden, mantissa}
  localparam int XW   = EXP_W + 2;   // headroom for exp+1 overflow
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  state_t state_q, state_d;
  logic [FP_W-1:0] op_a_q, op_a_d;
  logic [FP_W-1:0] op_b_q, op_b_d;
  logic            sign_q, sign_d;
  logic            eff_sub_q, eff_sub_d;
  logic [XW-1:0]   exp_q, exp_d;
  logic [SW-1:0]   mant_q, mant_d;
  logic [FW-1:0]   mant_b_q, mant_b_d;
  logic            zero_q, zero_d;
  logic            zero_nx_q, zero_nx_d;
  logic [FP_W-1:0] result_q, result_d;
  logic [2:0]      flags_q, flags_d;

  // ---------------- accept-cycle decode and special results ----------------
  logic             a_sign, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_man, b_man;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
  logic             special;
  logic [FP_W-1:0]  spec_result;
  logic [2:0]       spec_flags;

  assign a_sign = in_a[FP_W-1];
  assign a_exp  = in_a[FP_W-2:MAN_W];
  assign a_man  = in_a[MAN_W-1:0];
  assign b_sign = in_b[FP_W-1] ^ in_sub;
  assign b_exp  = in_b[FP_W-2:MAN_W];
  assign b_man  = in_b[MAN_W-1:0];

  always_comb begin
    // A zero exponent covers both true zeros and flushed subnormals.
    a_zero  = (a_exp == '0);
    b_zero  = (b_exp == '0);
    a_inf   = (a_exp == EXP_ONES) && (a_man == '0);
    b_inf   = (b_exp == EXP_ONES) && (b_man == '0);
    a_nan   = (a_exp == EXP_ONES) && (a_man != '0);
    b_nan   = (b_exp == EXP_ONES) && (b_man != '0);
    a_snan  = a_nan && !a_man[MAN_W-1];
    b_snan  = b_nan && !b_man[MAN_W-1];
    special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;

    spec_result = '0;
    spec_flags  = '0;
    if (a_nan || b_nan) begin
      spec_result          = QNAN_CANON;
      spec_flags[FLAG_NV]  = a_snan | b_snan;
    end else if (a_inf && b_inf) begin
      if (a_sign != b_sign) begin
        spec_result         = QNAN_CANON;
        spec_flags[FLAG_NV] = 1'b1;
      end else begin
        spec_result = {a_sign, EXP_ONES, {MAN_W{1'b0}}};
      end
    end else if (a_inf) begin
      spec_result = {a_sign, EXP_ONES, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      spec_result = {b_sign, EXP_ONES, {MAN_W{1'b0}}};
    end else if (a_zero && b_zero) begin
      spec_result = {a_sign & b_sign, {(FP_W-1){1'b0}}};
    end else if (a_zero) begin
      spec_result = {b_sign, b_exp, b_man};
    end else begin
      spec_result = {a_sign, a_exp, a_man};
    end
  end

  // ---------------- alignment ----------------
  logic             swap;
  logic [EXP_W-1:0] big_exp, small_exp, exp_diff, shamt;
  logic [MAN_W-1:0] big_man, small_man;
  logic [2*FW-1:0]  small_wide;
  logic [FW-1:0]    small_aligned;

  always_comb begin
    // Exponent and mantissa are contiguous, so one compare orders magnitudes.
    swap      = op_b_q[FP_W-2:0] > op_a_q[FP_W-2:0];
    big_exp   = swap ? op_b_q[FP_W-2:MAN_W] : op_a_q[FP_W-2:MAN_W];
    big_man   = swap ? op_b_q[MAN_W-1:0]    : op_a_q[MAN_W-1:0];
    small_exp = swap ? op_a_q[FP_W-2:MAN_W] : op_b_q[FP_W-2:MAN_W];
    small_man = swap ? op_a_q[MAN_W-1:0]    : op_b_q[MAN_W-1:0];
    exp_diff  = big_exp - small_exp;
    shamt     = (exp_diff > EXP_W'(FW)) ? EXP_W'(FW) : exp_diff;
    small_wide    = {1'b1, small_man, 3'b000, {FW{1'b0}}} >> shamt;
    small_aligned = {small_wide[2*FW-1:FW+1], small_wide[FW] | (|small_wide[FW-1:0])};
  end

  // ---------------- normalization ----------------
  logic [LZC_W-1:0] lz;
  logic [XW-1:0]    lz_m1, exp_m1, norm_sh;
  logic [SW-1:0]    norm_mant;

  leading_zeroth_bit #(
    .Bit_Length  (NW),
    .Bit_Length_O(LZC_W)
  ) u_lzc (
    .in_bits(mant_q[SW-1:3]),
    .lz     (lz)
  );

  always_comb begin
    lz_m1     = XW'(lz) - XW'(1);
    exp_m1    = exp_q - XW'(1);
    norm_sh   = (lz_m1 < exp_m1) ? lz_m1 : exp_m1;
    norm_mant = mant_q << norm_sh;
  end

  // ---------------- rounding ----------------
  logic            rnd_g, rnd_r, rnd_s, rnd_up;
  logic [NW-1:0]   rnd_mant;
  logic [XW-1:0]   rnd_exp;
  logic [MAN_W-1:0] rnd_frac;
  logic [FP_W-1:0] rnd_result;
  logic [2:0]      rnd_flags;

  always_comb begin
    rnd_g    = mant_q[2];
    rnd_r    = mant_q[1];
    rnd_s    = mant_q[0];
    rnd_up   = rnd_g & (rnd_r | rnd_s | mant_q[3]);
    rnd_mant = {1'b0, mant_q[SW-2:3]} + NW'(rnd_up);
    rnd_exp  = exp_q;
    rnd_frac = rnd_mant[MAN_W-1:0];
    if (rnd_mant[NW-1]) begin
      rnd_exp  = exp_q + XW'(1);
      rnd_frac = rnd_mant[MAN_W:1];
    end

    rnd_result = '0;
    rnd_flags  = '0;
    if (zero_q) begin
      rnd_result          = {sign_q, {(FP_W-1){1'b0}}};
      rnd_flags[FLAG_NX]  = zero_nx_q;
    end else if (rnd_exp >= XW'(EXP_ONES)) begin
      rnd_result          = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
      rnd_flags[FLAG_OF]  = 1'b1;
      rnd_flags[FLAG_NX]  = 1'b1;
    end else begin
      rnd_result          = {sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
      rnd_flags[FLAG_NX]  = rnd_g | rnd_r | rnd_s;
    end
  end

  // ---------------- FSM next state ----------------
  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    sign_d    = sign_q;
    eff_sub_d = eff_sub_q;
    exp_d     = exp_q;
    mant_d    = mant_q;
    mant_b_d  = mant_b_q;
    zero_d    = zero_q;
    zero_nx_d = zero_nx_q;
    result_d  = result_q;
    flags_d   = flags_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_a_d    = in_a;
          op_b_d    = {b_sign, in_b[FP_W-2:0]};
          zero_d    = 1'b0;
          zero_nx_d = 1'b0;
          if (special) begin
            result_d = spec_result;
            flags_d  = spec_flags;
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_ALIGN;
          end
        end
      end
      ST_ALIGN: begin
        sign_d    = swap ? op_b_q[FP_W-1] : op_a_q[FP_W-1];
        eff_sub_d = op_a_q[FP_W-1] ^ op_b_q[FP_W-1];
        exp_d     = XW'(big_exp);
        mant_d    = {2'b01, big_man, 3'b000};
        mant_b_d  = small_aligned;
        state_d   = ST_ADD;
      end
      ST_ADD: begin
        mant_d  = eff_sub_q ? (mant_q - {1'b0, mant_b_q}) : (mant_q + {1'b0, mant_b_q});
        state_d = ST_NORM;
      end
      ST_NORM: begin
        if (mant_q[SW-1]) begin
          mant_d = {1'b0, mant_q[SW-1:2], mant_q[1] | mant_q[0]};
          exp_d  = exp_q + XW'(1);
        end else if (mant_q == '0) begin
          // Exact cancellation always yields +0 here; -0 - (+0) is a special case.
          zero_d    = 1'b1;
          zero_nx_d = 1'b0;
          sign_d    = 1'b0;
        end else begin
          mant_d = norm_mant;
          exp_d  = exp_q - norm_sh;
          if (!norm_mant[SW-2]) begin
            zero_d    = 1'b1;
            zero_nx_d = 1'b1;
          end
        end
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        result_d = rnd_result;
        flags_d  = rnd_flags;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_a_q    <= '0;
      op_b_q    <= '0;
      sign_q    <= 1'b0;
      eff_sub_q <= 1'b0;
      exp_q     <= '0;
      mant_q    <= '0;
      mant_b_q  <= '0;
      zero_q    <= 1'b0;
      zero_nx_q <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      sign_q    <= sign_d;
      eff_sub_q <= eff_sub_d;
      exp_q     <= exp_d;
      mant_q    <= mant_d;
      mant_b_q  <= mant_b_d;
      zero_q    <= zero_d;
      zero_nx_q <= zero_nx_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign out_result = result_q;
  assign out_flags  = flags_q;

endmodule
